// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the multi-cycle RV32I core; issues one instruction-memory read per accepted request.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   instrfetch, pc    level fetch request and program counter from the control FSM
//   imem_req/addr     one-cycle read strobe and latched byte address to instruction memory
//   imem_rdata/valid  returned word and its valid qualifier
//   instr             last successfully fetched word (RESET_INSTR after reset)
//   instr_fetched     one-cycle completion pulse
//   fetch_err, halt   sticky error (misaligned PC or timeout) and halt (error, ECALL or EBREAK)
module instr_fetch_unit #(
  parameter int          ADDR_W      = 32,
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instrfetch,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instr,
  output logic              instr_fetched,
  output logic              fetch_err,
  output logic              halt
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, REARM, ERR} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic aligned, accept, misalign, timeout, is_sys;
  assign aligned       = pc[1:0] == 2'b00;
  assign accept        = state == IDLE && instrfetch && aligned;
  assign misalign      = state == IDLE && instrfetch && !aligned;
  assign timeout       = state == WAIT && !imem_valid && cnt == CW'(TIMEOUT - 1);
  assign is_sys        = instr == 32'h0000_0073 || instr == 32'h0010_0073;
  assign imem_req      = state == REQ;
  assign instr_fetched = state == DONE;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !instrfetch ? IDLE : aligned ? REQ : ERR;
      REQ:     next = WAIT;
      WAIT:    next = imem_valid ? DONE : timeout ? ERR : WAIT;
      DONE:    next = REARM;
      REARM:   next = instrfetch ? REARM : IDLE;
      ERR:     next = ERR;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_addr <= '0;
      instr     <= RESET_INSTR;
      cnt       <= '0;
      fetch_err <= 1'b0;
      halt      <= 1'b0;
    end else begin
      if (accept) imem_addr <= pc;
      if (state == REQ) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (state == WAIT && imem_valid) instr <= imem_rdata;
      if (misalign || timeout) begin
        fetch_err <= 1'b1;
        halt      <= 1'b1;
      end
      if (state == DONE && is_sys) halt <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a cycle-timeline model of instr_fetch_unit.
module tb_instr_fetch_unit;
  localparam int          TO = 16;
  localparam logic [31:0] RI = 32'h0000_0013;
  logic        clk, rst_n, instrfetch, imem_req, imem_valid, instr_fetched, fetch_err, halt;
  logic [31:0] pc, imem_addr, imem_rdata, instr;
  int n_cmp = 0, n_err = 0;
  instr_fetch_unit #(.ADDR_W(32), .TIMEOUT(TO), .RESET_INSTR(RI)) dut (
    .clk(clk), .rst_n(rst_n), .instrfetch(instrfetch), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .instr_fetched(instr_fetched), .fetch_err(fetch_err), .halt(halt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask
  // Model: time is counted in clock edges; a fetch accepted at edge A requests in the
  // period after A, watches for valid during the TO periods after that, and completes
  // (pulse) in the period after the edge that saw valid.
  int          cyc = 0, acc = 0, req_at = -1, pulse_at = -1;
  bit          started = 0, busy = 0, need_low = 0, dead = 0, sys = 0;
  logic [31:0] m_instr = RI, m_addr = 0;
  logic        m_err = 0, m_halt = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      started = 1; busy = 0; need_low = 0; dead = 0; sys = 0;
      req_at = -1; pulse_at = -1;
      m_instr = RI; m_addr = 0; m_err = 0; m_halt = 0;
    end else if (!dead) begin
      if (sys && cyc == pulse_at + 1) m_halt = 1;
      if (busy && cyc - 1 >= acc + 1) begin
        if (imem_valid) begin
          m_instr = imem_rdata; pulse_at = cyc; busy = 0; need_low = 1;
          sys = imem_rdata == 32'h0000_0073 || imem_rdata == 32'h0010_0073;
        end else if (cyc - 1 == acc + TO) begin
          m_err = 1; m_halt = 1; dead = 1; busy = 0;
        end
      end else if (need_low) begin
        if (cyc - 1 > pulse_at && !instrfetch) need_low = 0;
      end else if (!busy && instrfetch) begin
        if (pc[1:0] != 2'b00) begin
          m_err = 1; m_halt = 1; dead = 1;
        end else begin
          m_addr = pc; busy = 1; acc = cyc; req_at = cyc;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, cyc == req_at});
      check("imem_addr", imem_addr, m_addr);
      check("instr", instr, m_instr);
      check("instr_fetched", {31'b0, instr_fetched}, {31'b0, cyc == pulse_at});
      check("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
      check("halt", {31'b0, halt}, {31'b0, m_halt});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drop();
    instrfetch = 1'b0;
    tick();
    tick();
  endtask
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int lat, input logic [31:0] pc_mid);
    int reqs = 0;
    pc = a; instrfetch = 1'b1;
    tick(); reqs += int'(imem_req);
    for (int i = 0; i < lat; i++) begin
      tick(); reqs += int'(imem_req);
      if (i == 0) pc = pc_mid;
    end
    imem_valid = 1'b1; imem_rdata = d;
    tick(); reqs += int'(imem_req);
    imem_valid = 1'b0;
    check("lit_fetched", {31'b0, instr_fetched}, 32'd1);
    check("lit_instr", instr, d);
    check("lit_addr", imem_addr, a);
    check("lit_req_pulses", 32'(reqs), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int reqs;
    rst_n = 1'b0; instrfetch = 1'b0; pc = 0; imem_valid = 1'b0; imem_rdata = 0;
    tick(); tick();
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_flags", {28'b0, imem_req, instr_fetched, fetch_err, halt}, 32'h0);
    rst_n = 1'b1;
    tick();
    do_fetch(32'h10, 32'h0050_0093, 1, 32'h10);
    check("basic_halt", {31'b0, halt}, 32'd0);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); reqs += int'(imem_req);
    end
    check("held_no_req", 32'(reqs), 32'd0);
    check("held_instr", instr, 32'h0050_0093);
    drop();
    do_fetch(32'h14, 32'h00a0_0113, 1, 32'h14);
    drop();
    do_fetch(32'h10, 32'h0020_8193, 5, 32'h20);
    check("varlat_addr", imem_addr, 32'h10);
    drop();
    do_fetch(32'h18, 32'h0000_0073, 2, 32'h18);
    check("ecall_halt_pre", {31'b0, halt}, 32'd0);
    tick();
    check("ecall_halt", {31'b0, halt}, 32'd1);
    check("ecall_err", {31'b0, fetch_err}, 32'd0);
    drop();
    pc = 32'h1c; instrfetch = 1'b1;
    tick(); tick();
    rst_n = 1'b0; instrfetch = 1'b0;
    tick();
    check("midrst_instr", instr, 32'h0000_0013);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_flags", {28'b0, imem_req, instr_fetched, fetch_err, halt}, 32'h0);
    rst_n = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hdead_beef;
    tick();
    imem_valid = 1'b0;
    tick();
    check("late_valid_instr", instr, 32'h0000_0013);
    pc = 32'h6; instrfetch = 1'b1;
    tick();
    check("mis_err", {31'b0, fetch_err}, 32'd1);
    check("mis_halt", {31'b0, halt}, 32'd1);
    reqs = int'(imem_req);
    for (int i = 0; i < 4; i++) begin
      tick(); reqs += int'(imem_req) + int'(instr_fetched);
    end
    check("mis_no_req", 32'(reqs), 32'd0);
    rst_n = 1'b0; instrfetch = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pc = 32'h40; instrfetch = 1'b1;
    tick();
    repeat (TO) tick();
    check("to_err_pre", {31'b0, fetch_err}, 32'd0);
    tick();
    check("to_err", {31'b0, fetch_err}, 32'd1);
    check("to_halt", {31'b0, halt}, 32'd1);
    imem_valid = 1'b1; imem_rdata = 32'hcafe_f00d;
    tick();
    imem_valid = 1'b0;
    tick();
    check("to_instr", instr, 32'h0000_0013);
    check("to_err_sticky", {31'b0, fetch_err}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the multi-cycle RV32I core. It sits directly upstream of the control FSM and feeds it.
- Accepts the control FSM's level request `instrfetch` together with the current PC, and drives a variable-latency instruction-memory read.
- Registers the returned word and reports completion to the FSM with a one-cycle `instr_fetched` pulse.
- Flags misaligned PCs and memory timeouts, and raises `halt` on ECALL/EBREAK.

Parameters:
- ADDR_W, 32, width of the PC and the instruction-memory address.
- TIMEOUT, 16, maximum cycles to wait for `imem_valid` before declaring a fetch error (must be ≥2).
- RESET_INSTR, 32'h00000013, value held in `instr` after reset (NOP: addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- instrfetch  in  1  level fetch request from the control FSM.
- pc  in  ADDR_W  current program counter; sampled when a request is accepted.
- imem_req  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  byte address to instruction memory.
- imem_rdata  in  32  instruction word returned by memory.
- imem_valid  in  1  `imem_rdata` is valid this cycle.
- instr  out  32  registered fetched instruction, stable until the next successful fetch.
- instr_fetched  out  1  one-cycle completion pulse to the control FSM.
- fetch_err  out  1  sticky error: misaligned PC or timeout.
- halt  out  1  sticky halt request to the control FSM.

Behaviour:
- Reset (`rst_n`=0 at posedge): state=IDLE, `imem_req`=0, `imem_addr`=0, `instr`=RESET_INSTR, `instr_fetched`=0, `fetch_err`=0, `halt`=0, timeout counter=0. Reset overrides any in-flight fetch; a late `imem_valid` after reset is ignored.
- States: IDLE, REQ, WAIT, DONE, REARM, ERR.
- IDLE
  - `instrfetch`=1 and `pc[1:0]`==0: latch `pc` into `imem_addr`, go to REQ.
  - `instrfetch`=1 and `pc[1:0]`!=0: set `fetch_err`=1 and `halt`=1, go to ERR. No memory request is issued.
  - Otherwise stay in IDLE.
- REQ
  - `imem_req`=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT
  - `imem_req`=0.
  - `imem_valid`=1: load `imem_rdata` into `instr`; go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no valid, set `fetch_err`=1 and `halt`=1; go to ERR.
  - `imem_valid` seen in any state other than WAIT is ignored.
- DONE
  - `instr_fetched`=1 for exactly this one cycle.
  - If `instr` is ECALL (32'h00000073) or EBREAK (32'h00100073), set `halt`=1.
  - Go to REARM.
- REARM
  - Wait for `instrfetch`=0, then go to IDLE. A held request is never re-fetched.
  - `instrfetch` low and high again with no idle cycle in between is impossible by construction. Minimum gap between accepted requests: 1 idle cycle with `instrfetch`=0.
- ERR
  - Terminal. All outputs hold and `imem_req`=0.
  - Left only by reset.
- Latency
  - `instrfetch` accepted at edge N: `imem_req` high in cycle N+1.
  - `imem_valid` in cycle N+1+L (L≥1): `instr` updated and `instr_fetched` high in cycle N+2+L.
  - Minimum fetch latency with L=1 is 3 cycles from acceptance to pulse.
- Stability guarantees
  - `instr` changes only on a valid capture or on reset.
  - `pc` changes after acceptance have no effect on the in-flight fetch.
- `halt` and `fetch_err` are sticky until reset.

Test Plan:
- Basic fetch
  - Stimulus: reset; `pc`=0x00000010, `instrfetch`=1; memory returns 0x00500093 with L=1.
  - Response: `imem_req` pulse with `imem_addr`=0x10; `instr`=0x00500093; single `instr_fetched` pulse 3 cycles after acceptance; `halt`=0.
- Variable latency
  - Stimulus: `imem_valid` delayed L=5; `pc` changes to 0x20 mid-wait.
  - Response: `imem_addr` stays 0x10; `instr_fetched` 7 cycles after acceptance; exactly one `imem_req` pulse.
- Held request
  - Stimulus: `instrfetch` kept high for 10 cycles after the pulse.
  - Response: no second `imem_req`.
  - Follow-up: drop `instrfetch` 1 cycle, raise with `pc`=0x14 → new fetch from 0x14.
- Misaligned PC
  - Stimulus: `pc`=0x00000006, `instrfetch`=1.
  - Response: `fetch_err`=1 and `halt`=1 next cycle; `imem_req` never asserted; no `instr_fetched`.
- Timeout
  - Stimulus: TIMEOUT=16, memory never responds.
  - Response: `fetch_err`=`halt`=1 after 16 WAIT cycles; a later `imem_valid` does not change `instr`.
- ECALL and reset mid-fetch
  - Stimulus: memory returns 0x00000073.
  - Response: `instr_fetched` pulse, `halt`=1.
  - Follow-up: `rst_n`=0 during a WAIT → all outputs return to reset values next edge; `instr`=0x00000013.
